// File: rtl/menu_controller_pkg.sv
// menu_controller_pkg: shared state encodings, press codes and encoder home position.
package menu_controller_pkg;
  typedef enum logic {BROWSE, EDIT} state_t;
  localparam logic [1:0] PB_NONE   = 2'd0;
  localparam logic [1:0] PB_SHORT  = 2'd1;
  localparam logic [1:0] PB_NORMAL = 2'd2;
  localparam logic [1:0] PB_LONG   = 2'd3;
  localparam logic [3:0] ENC_HOME  = 4'd8;
endpackage

// File: rtl/menu_controller_enc_step_decode.sv
// enc_step_decode: turns encoder position changes into +1/-1 steps, masking press-related jumps.
module enc_step_decode
  import menu_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] enc,
  input  logic       press,
  output logic       step_up,
  output logic       step_dn
);
  logic [3:0] enc_q, enc_d;
  logic       supp_q, supp_d;
  always_comb begin
    enc_d  = enc;
    supp_d = press;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enc_q  <= ENC_HOME;
      supp_q <= 1'b0;
    end else begin
      enc_q  <= enc_d;
      supp_q <= supp_d;
    end
  end
  // The encoder snaps back to home after a press report; ignore that jump.
  assign step_up = !press && !supp_q && (enc == enc_q + 4'd1);
  assign step_dn = !press && !supp_q && (enc == enc_q - 4'd1);
endmodule

// File: rtl/menu_controller.sv
// menu_controller: browse/edit menu FSM over a bank of committed parameter registers.
module menu_controller
  import menu_controller_pkg::*;
#(
  parameter int NPARAM  = 4,
  parameter int W       = 8,
  parameter int DEF_VAL = 128,
  parameter int TIMEOUT = 10000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [3:0]                enc,
  input  logic [1:0]                pb_press_type,
  output logic [NPARAM*W-1:0]       params,
  output logic [$clog2(NPARAM)-1:0] sel,
  output logic [W-1:0]              edit_val,
  output logic                      editing,
  output logic                      cfg_wr,
  output logic [$clog2(NPARAM)-1:0] cfg_addr
);
  localparam int SW = $clog2(NPARAM);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SEL_MAX = SW'(NPARAM - 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT - 1);
  localparam logic [W-1:0] DEF = W'(DEF_VAL);
  state_t        state_q, state_d;
  logic [W-1:0]  params_q [NPARAM];
  logic [W-1:0]  params_d [NPARAM];
  logic [SW-1:0] sel_q, sel_d, cfg_addr_q, cfg_addr_d;
  logic [W-1:0]  edit_val_q, edit_val_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          editing_q, editing_d, cfg_wr_q, cfg_wr_d;
  logic          step_up, step_dn;
  enc_step_decode u_dec (
    .clk    (clk),
    .rstn   (rstn),
    .enc    (enc),
    .press  (pb_press_type != PB_NONE),
    .step_up(step_up),
    .step_dn(step_dn)
  );
  always_comb begin
    state_d    = state_q;
    params_d   = params_q;
    sel_d      = sel_q;
    edit_val_d = edit_val_q;
    idle_d     = idle_q;
    cfg_wr_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    if (pb_press_type == PB_LONG) begin
      for (int i = 0; i < NPARAM; i++) params_d[i] = DEF;
      sel_d      = '0;
      state_d    = BROWSE;
      cfg_wr_d   = 1'b1;
      cfg_addr_d = SEL_MAX;
    end else if (state_q == BROWSE) begin
      if (pb_press_type == PB_SHORT) state_d = EDIT;
      else if (step_up) sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
      else if (step_dn) sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
    end else if (pb_press_type == PB_SHORT) begin
      params_d[sel_q] = edit_val_q;
      cfg_wr_d        = 1'b1;
      cfg_addr_d      = sel_q;
      state_d         = BROWSE;
    end else if (pb_press_type == PB_NORMAL) begin
      state_d = BROWSE;
    end else if (step_up) begin
      edit_val_d = (&edit_val_q) ? edit_val_q : edit_val_q + 1'b1;
      idle_d     = '0;
    end else if (step_dn) begin
      edit_val_d = (edit_val_q == '0) ? edit_val_q : edit_val_q - 1'b1;
      idle_d     = '0;
    end else if (idle_q == IDLE_MAX) begin
      state_d = BROWSE;
    end else begin
      idle_d = idle_q + 1'b1;
    end
    // Outside EDIT the working value mirrors the selected committed value.
    if (state_d == BROWSE) begin
      idle_d     = '0;
      edit_val_d = params_d[sel_d];
    end
    editing_d = (state_d == EDIT);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BROWSE;
      for (int i = 0; i < NPARAM; i++) params_q[i] <= DEF;
      sel_q      <= '0;
      edit_val_q <= DEF;
      idle_q     <= '0;
      editing_q  <= 1'b0;
      cfg_wr_q   <= 1'b0;
      cfg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      params_q   <= params_d;
      sel_q      <= sel_d;
      edit_val_q <= edit_val_d;
      idle_q     <= idle_d;
      editing_q  <= editing_d;
      cfg_wr_q   <= cfg_wr_d;
      cfg_addr_q <= cfg_addr_d;
    end
  end
  for (genvar i = 0; i < NPARAM; i++) begin : g_p
    assign params[i*W +: W] = params_q[i];
  end
  assign sel      = sel_q;
  assign edit_val = edit_val_q;
  assign editing  = editing_q;
  assign cfg_wr   = cfg_wr_q;
  assign cfg_addr = cfg_addr_q;
endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed checks of browse, edit, commit, cancel, timeout, masking, restore and reset.
module tb_menu_controller;
  localparam int TMO = 20;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  enc = 4'd8;
  logic [1:0]  pb = 2'd0;
  logic [31:0] params;
  logic [1:0]  sel, cfg_addr;
  logic [7:0]  edit_val;
  logic        editing, cfg_wr;
  int          n_chk = 0;
  int          n_pass = 0;
  menu_controller #(.NPARAM(4), .W(8), .DEF_VAL(128), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enc          (enc),
    .pb_press_type(pb),
    .params       (params),
    .sel          (sel),
    .edit_val     (edit_val),
    .editing      (editing),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic up(input int n = 1);
    repeat (n) begin
      enc = enc + 4'd1;
      cyc();
    end
  endtask
  task automatic dn(input int n = 1);
    repeat (n) begin
      enc = enc - 4'd1;
      cyc();
    end
  endtask
  task automatic press(input logic [1:0] code);
    pb = code;
    cyc();
    pb = 2'd0;
    enc = 4'd8;
  endtask
  initial begin
    cyc(3);
    check("rst_sel", sel, 0);
    check("rst_params", params, 32'h80808080);
    check("rst_edit", edit_val, 128);
    check("rst_editing", editing, 0);
    check("rst_cfg_wr", cfg_wr, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    rstn = 1'b1;
    cyc();
    check("post_rst_sel", sel, 0);
    dn();
    check("wrap_dn_sel", sel, 3);
    up(2);
    check("wrap_up_sel", sel, 1);
    up();
    check("sel2", sel, 2);
    press(2'd1);
    check("edit_enter", editing, 1);
    check("edit_load", edit_val, 128);
    cyc();
    check("edit_mask", edit_val, 128);
    up(3);
    check("edit_up3", edit_val, 131);
    check("sel_frozen", sel, 2);
    press(2'd1);
    check("commit_wr", cfg_wr, 1);
    check("commit_addr", cfg_addr, 2);
    check("commit_p2", params[23:16], 131);
    check("commit_editing", editing, 0);
    check("commit_browse_val", edit_val, 131);
    cyc();
    check("commit_wr_pulse", cfg_wr, 0);
    up();
    check("mask_pre_sel", sel, 3);
    press(2'd2);
    check("browse_normal_sel", sel, 3);
    check("browse_normal_editing", editing, 0);
    cyc();
    check("jump_mask_sel", sel, 3);
    dn(2);
    check("sel1", sel, 1);
    press(2'd1);
    cyc();
    up(130);
    check("sat_hi", edit_val, 255);
    press(2'd2);
    check("cancel_editing", editing, 0);
    check("cancel_wr", cfg_wr, 0);
    check("cancel_p1", params[15:8], 128);
    check("cancel_browse_val", edit_val, 128);
    cyc();
    press(2'd1);
    cyc();
    dn();
    check("tmo_dn", edit_val, 127);
    cyc(TMO - 1);
    check("tmo_not_yet", editing, 1);
    cyc();
    check("tmo_editing", editing, 0);
    check("tmo_wr", cfg_wr, 0);
    check("tmo_params", params, 32'h80838080);
    press(2'd1);
    cyc();
    dn(130);
    check("sat_lo", edit_val, 0);
    press(2'd1);
    check("commit0_wr", cfg_wr, 1);
    check("commit0_p1", params[15:8], 0);
    cyc();
    press(2'd1);
    cyc();
    press(2'd1);
    check("same_commit_wr", cfg_wr, 1);
    check("same_commit_addr", cfg_addr, 1);
    check("pre_restore", params, 32'h80830080);
    cyc();
    press(2'd3);
    check("restore_params", params, 32'h80808080);
    check("restore_sel", sel, 0);
    check("restore_wr", cfg_wr, 1);
    check("restore_addr", cfg_addr, 3);
    cyc();
    check("restore_wr_pulse", cfg_wr, 0);
    press(2'd1);
    cyc();
    up();
    check("long_edit_pre", edit_val, 129);
    press(2'd3);
    check("long_edit_editing", editing, 0);
    check("long_edit_val", edit_val, 128);
    check("long_edit_wr", cfg_wr, 1);
    cyc();
    up();
    check("pre_rst_sel", sel, 1);
    press(2'd1);
    cyc();
    up(2);
    check("pre_rst_edit", edit_val, 130);
    rstn = 1'b0;
    #1;
    check("arst_sel", sel, 0);
    check("arst_edit", edit_val, 128);
    check("arst_editing", editing, 0);
    check("arst_cfg_addr", cfg_addr, 0);
    check("arst_params", params, 32'h80808080);
    cyc(2);
    check("arst_wr", cfg_wr, 0);
    enc = 4'd8;
    rstn = 1'b1;
    cyc();
    check("rel_sel", sel, 0);
    check("rel_editing", editing, 0);
    check("rel_wr", cfg_wr, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/menu_controller.md
MENU_CONTROLLER -- requirements
Module: menu_controller

Interface
REQ-001 Parameter NPARAM, default 4, number of configurable parameters (2..8).
REQ-002 Parameter W, default 8, width of each parameter value.
REQ-003 Parameter DEF_VAL, default 128, reset/restore value of every parameter.
REQ-004 Parameter TIMEOUT, default 10000, idle clk cycles in EDIT before auto-cancel (10 s at 1 kHz).
REQ-005 clk  input  1  single clock, shared with the encoder front end (1 kHz).
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 enc  input  4  encoder position from the rotational encoder front end; it is 8 after reset and after each press report.
REQ-008 pb_press_type  input  2  press code: 0 none, 1 short, 2 normal, 3 long; a nonzero value is a one-cycle pulse.
REQ-009 params  output  NPARAM*W  committed parameter values, with parameter i in bits [i*W +: W].
REQ-010 sel  output  clog2(NPARAM)  currently selected parameter index.
REQ-011 edit_val  output  W  working value while editing; equals params[sel] in BROWSE.
REQ-012 editing  output  1  high while in EDIT.
REQ-013 cfg_wr  output  1  one-cycle pulse when params changes.
REQ-014 cfg_addr  output  clog2(NPARAM)  index written on cfg_wr; equals NPARAM-1 on restore-all.

Function
REQ-015 Step decode: register enc as enc_q; step is +1 when enc == enc_q+1 (mod 16), -1 when enc == enc_q-1 (mod 16), otherwise 0.
REQ-016 Steps are suppressed in the cycle of a press event and in the cycle after it, which masks the encoder's jump back to 8.
REQ-017 Event priority within one cycle: long press > other press > step > timeout.
REQ-018 States: BROWSE and EDIT; state is BROWSE after reset.
REQ-019 BROWSE, step ±1: sel changes by ±1 and wraps between 0 and NPARAM-1.
REQ-020 BROWSE, short press: go to EDIT; load edit_val with params[sel]; clear the idle counter.
REQ-021 BROWSE, normal press: no effect.
REQ-022 EDIT, step ±1: edit_val changes by ±1, saturating at 0 and at 2^W-1; the idle counter clears.
REQ-023 EDIT, short press (commit): params[sel] takes edit_val; cfg_wr=1 and cfg_addr=sel on the next cycle; return to BROWSE.
REQ-024 A commit whose value is unchanged still pulses cfg_wr.
REQ-025 EDIT, normal press (cancel): discard edit_val; params is unchanged; no cfg_wr; return to BROWSE.
REQ-026 EDIT, idle counter reaching TIMEOUT-1 with no event: behave exactly as a cancel.
REQ-027 The idle counter saturates and is active only in EDIT.
REQ-028 Long press in either state (restore-all): every parameter takes DEF_VAL; sel=0; one cfg_wr pulse with cfg_addr=NPARAM-1; state goes to BROWSE.
REQ-029 All outputs are registered; event-to-output latency is 1 clk.
REQ-030 sel is frozen while in EDIT.

Reset
REQ-031 On rstn low: state=BROWSE, sel=0, every parameter=DEF_VAL, edit_val=DEF_VAL, editing=0, cfg_wr=0, cfg_addr=0, enc_q=8, idle counter=0, suppress flag=0.
REQ-032 Reset asserted mid-EDIT abandons the edit with no cfg_wr.
REQ-033 After reset deassertion the first active edge is a normal cycle with no spurious step.

Structure
REQ-034 The shared package/include holds the state encodings, the press-code constants (NONE/SHORT/NORMAL/LONG), and the default ENC_HOME=8.
REQ-035 Step decoding is one sub-module, enc_step_decode (inputs enc and press-event; outputs step_up and step_dn).
REQ-036 The controller is a single FSM with a register-array datapath in menu_controller.

Verification
REQ-037 Browse wrap: enc 8→7 with sel=0 → sel=3; then 7→8→9 → sel=1.
REQ-038 Edit/commit: short press on sel=2, three up-steps, short press → params[2]=131, cfg_wr for one cycle with cfg_addr=2, editing=0.
REQ-039 Cancel/saturate: edit sel=1, 130 up-steps → edit_val=255; normal press → params[1] stays 128, no cfg_wr.
REQ-040 Press-jump masking: enc at 12 when a press pulse occurs, enc then forced to 8 → no step decoded, sel/edit_val unchanged by the jump.
REQ-041 Timeout: enter EDIT, one step, then TIMEOUT idle cycles → editing=0, params unchanged, no cfg_wr.
REQ-042 Restore and reset: modify params[0..3], long press → all 128, sel=0, one cfg_wr; rstn pulsed mid-EDIT → every REQ-031 value holds, no cfg_wr.
